// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   INSTR_W           : instruction word width
//   OP_MSB / OP_LSB   : bit range of the opcode field inside an instruction
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   fetch_state_t     : fetch FSM states
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its PC+4.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   push_i               : capture instr_i / pc_plus4_i (only when empty)
//   pop_i                : release the held entry
//   flush_i              : discard the held entry (wins over push/pop)
//   instr_i, pc_plus4_i  : payload to capture
//   full_o               : entry valid
//   instr_o, pc_plus4_o  : held payload
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_plus4_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus4_o
);

    logic               full_q,     full_d;
    logic [INSTR_W-1:0] instr_q,    instr_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;

    // Next-state: flush beats push, push beats pop.
    always_comb begin
        full_d     = full_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d     = 1'b1;
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q     <= 1'b0;
            instr_q    <= {INSTR_W{1'b0}};
            pc_plus4_q <= {ADDR_W{1'b0}};
        end else begin
            full_q     <= full_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign full_o     = full_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule : fetch_skid_buf

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction
// memory (one-cycle latency) and hands instruction / opcode / PC+4 to decode
// over a valid/stall handshake. Branch/jump redirects flush and refetch.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o      : memory read request and word address
//   imem_instr_i                 : read data, valid the cycle after a request
//   redirect_i, redirect_pc_i    : taken branch/jump and its target
//   stall_i                      : decode cannot accept this cycle
//   valid_o, instr_o, instr_op_o, pc_plus4_o : payload to decode
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic [INSTR_W-1:0]       imem_instr_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    input  logic                     stall_i,
    output logic                     valid_o,
    output logic [INSTR_W-1:0]       instr_o,
    output logic [OP_MSB-OP_LSB:0]   instr_op_o,
    output logic [ADDR_W-1:0]        pc_plus4_o
);

    localparam logic [ADDR_W-1:0] FOUR       = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;

    logic               hold_s;
    logic               req_s;
    logic               skid_push_s;
    logic               skid_pop_s;
    logic               skid_full_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic [ADDR_W-1:0]  skid_pc_plus4_s;
    logic [ADDR_W-1:0]  resp_pc_plus4_s;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (skid_push_s),
        .pop_i      (skid_pop_s),
        .flush_i    (redirect_i),
        .instr_i    (imem_instr_i),
        .pc_plus4_i (resp_pc_plus4_s),
        .full_o     (skid_full_s),
        .instr_o    (skid_instr_s),
        .pc_plus4_o (skid_pc_plus4_s)
    );

    // FSM next state: BOOT lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Request rule, PC update, skid control and output register load.
    always_comb begin
        hold_s          = valid_q & stall_i;
        // A held output with a response already arriving fills the skid, so
        // no new request may be launched behind it.
        req_s           = (state_q == RUN) & ~redirect_i & ~skid_full_s
                          & ~(hold_s & inflight_q);
        resp_pc_plus4_s = inflight_pc_q + FOUR;
        skid_push_s     = ~redirect_i & hold_s & inflight_q;
        skid_pop_s      = ~redirect_i & ~hold_s & skid_full_s;

        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pc_plus4_d    = pc_plus4_q;

        if (redirect_i) begin
            // Any response arriving now is stale and simply dropped.
            pc_d    = redirect_pc_i & ALIGN_MASK;
            valid_d = 1'b0;
        end else begin
            if (req_s) begin
                pc_d          = pc_q + FOUR;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                inflight_d = 1'b0;
            end

            if (!hold_s) begin
                if (skid_full_s) begin
                    valid_d    = 1'b1;
                    instr_d    = skid_instr_s;
                    pc_plus4_d = skid_pc_plus4_s;
                end else if (inflight_q) begin
                    valid_d    = 1'b1;
                    instr_d    = imem_instr_i;
                    pc_plus4_d = resp_pc_plus4_s;
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // State, PC, in-flight tracking and output register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
            valid_q       <= 1'b0;
            instr_q       <= {INSTR_W{1'b0}};
            pc_plus4_q    <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pc_plus4_q    <= pc_plus4_d;
        end
    end

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_q;
    assign valid_o     = valid_q;
    assign instr_o     = instr_q;
    assign instr_op_o  = instr_q[OP_MSB:OP_LSB];
    assign pc_plus4_o  = pc_plus4_q;

endmodule : instr_fetch_unit

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the CPU. Owns the program counter and drives a synchronous instruction memory (one-cycle read latency). Delivers each instruction, its PC+4 and its opcode field to the decode stage over a valid/stall handshake, and accepts branch/jump redirects. A one-entry skid buffer absorbs the response already in flight when decode stalls.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset. Asynchronous, active-low.
- `imem_req_o`  out  1  read request this cycle.
- `imem_addr_o`  out  ADDR_W  read address; word-aligned.
- `imem_instr_i`  in  32  read data, valid the cycle after a request.
- `redirect_i`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc_i`  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- `stall_i`  in  1  decode cannot accept; hold `valid_o` and the payload.
- `valid_o`  out  1  payload valid.
- `instr_o`  out  32  fetched instruction.
- `instr_op_o`  out  6  `instr_o[31:26]`, the opcode field that feeds the decoder.
- `pc_plus4_o`  out  ADDR_W  fetch address + 4.

## Operation
- **FSM states.**
  - BOOT: first cycle after reset release; no request.
  - RUN: normal operation.
  - BOOT -> RUN unconditionally. There is no other exit from RUN except reset.
- **State held.**
  - `pc_q`: next fetch address.
  - `inflight_q` and `inflight_pc_q`: an outstanding response and its address.
  - `skid_q`: one entry holding instruction and PC+4.
  - Output register.
- **Request rule.** `imem_req_o = RUN & !redirect_i & !skid_valid & !(valid_o & stall_i & inflight_q)`.
  - `imem_addr_o = pc_q`.
  - On request: `pc_q <= pc_q + 4`, `inflight_q <= 1`, `inflight_pc_q <= pc_q`.
- **Output load.** Output loads when `!valid_o | !stall_i`.
  - Source is the skid entry if valid, otherwise the arriving response.
  - If no source exists, `valid_o <= 0`.
- **Skid capture.** A response that arrives while the output is held (`valid_o & stall_i`) goes into skid. The request rule guarantees skid is never written while full.
- **Redirect.** Redirect has priority over everything.
  - On the redirect edge: `pc_q <= {redirect_pc_i[ADDR_W-1:2],2'b00}`.
  - `inflight_q`, the skid entry and `valid_o` are all cleared.
  - A response arriving in the cycle after the redirect is discarded.
  - Redirect during stall still flushes the output.
- **Arithmetic.** PC+4 is computed modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0.
- **Reset values.**
  - `pc_q = RESET_PC`; state BOOT.
  - `imem_req_o = 0`, `valid_o = 0`, `instr_o = 0`, `instr_op_o = 0`, `pc_plus4_o = 0`.
  - `imem_addr_o = RESET_PC`.
- **Reset mid-operation.** All state is cleared immediately. In-flight responses are dropped.

## Timing
- Edge numbering: reset released before edge 0.
  - Edge 0: BOOT -> RUN.
  - Cycle after edge 0: request for `RESET_PC`.
  - `valid_o` goes high after edge 2 with `pc_plus4_o = RESET_PC + 4`.
- Steady state, no stall: one instruction per cycle. Request-to-`valid_o` latency is 2 edges.
- Redirect sampled at edge k:
  - Target requested in cycle k..k+1.
  - `valid_o` high after edge k+2.
  - Bubble of 2 cycles.
- Stall asserted with a response in flight: the response goes to skid and no request is issued that cycle.
- On stall release, the skid entry is presented on the next edge. Requests resume the same cycle the skid empties, so there is no lost or duplicated instruction.
- Payload is stable throughout any stall; it changes only on the edge after a cycle with `!stall_i`.

## Structure
- Shared package `cpu_pkg`:
  - `OP_MSB = 31`, `OP_LSB = 26`.
  - `INSTR_W = 32`.
  - Default `RESET_PC`.
  - Enum `fetch_state_t {BOOT, RUN}`.
- Sub-module `fetch_skid_buf`: one-entry buffer with `push`, `pop`, `flush`, `full`, and the instruction/PC+4 payload.
- Top level contains the PC, the FSM, the request rule and the output register.

## Test plan
- **Reset release.** Memory word n = 32'h1000_0000 + n. `valid_o` rises after edge 2 with `instr_o = 32'h1000_0000`, `pc_plus4_o = 4`, `instr_op_o = 6'h04`. Thereafter one word per cycle.
- **Stall.** Stall for 3 cycles mid-stream. Payload is frozen; the sequence resumes with no gaps or duplicates (e.g. 5, 6, 7 delivered in order).
- **Redirect to 32'h0000_0040.** No stall: stale words are dropped, and the output after edge k+2 is the word at 0x40 with `pc_plus4_o = 32'h44`. Repeat with the redirect while stalled and skid full: skid is flushed and the same result appears.
- **Misaligned target.** `redirect_pc_i = 32'h0000_0083` fetches 0x80.
- **Wrap.** Redirect to 32'hFFFF_FFFC: `pc_plus4_o = 0`, and the next fetch is address 0.
- **Reset mid-operation.** Assert `rst_i = 0` mid-stream, with an in-flight request and skid full. All outputs go to reset values immediately, and fetch restarts at `RESET_PC`.
